apb_cmd_master: RTL and testbench



---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_cmd_fifo.sv | 65 ++++++
 rtl/apb_cmd_master.sv | 123 ++++++++++++
 tb/tb_apb_cmd_master.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB command master.
// The FSM state encoding and the queued command layout live here.
package apb_pkg;

  localparam int AMBA_WORD_DEF       = 32;
  localparam int AMBA_ADDR_WIDTH_DEF = 20;
  localparam int CMD_DEPTH_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic                           write;
    logic [AMBA_ADDR_WIDTH_DEF-1:0] addr;
    logic [AMBA_WORD_DEF-1:0]       wdata;
  } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue in front of the APB FSM: power-of-2 depth, registered ready/empty.
// ready_o is held low during reset and rises on the first edge after release.
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int  DEPTH = CMD_DEPTH_DEF,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     push_data_i,
  output logic ready_o,
  input  logic pop_i,
  output T     head_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          ready_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign ready_o = ready_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator: pops queued commands and runs zero-wait SETUP/ACCESS transfers,
// returning one registered response beat per transfer.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int AMBA_WORD       = AMBA_WORD_DEF,
  parameter int AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_DEF,
  parameter int CMD_DEPTH       = CMD_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       busy,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA
);

  // Same layout as apb_pkg::cmd_t, sized to this instance's parameters.
  typedef struct packed {
    logic                       write;
    logic [AMBA_ADDR_WIDTH-1:0] addr;
    logic [AMBA_WORD-1:0]       wdata;
  } cmd_loc_t;

  cmd_loc_t push_cmd, head;
  logic     fifo_empty, pop;
  state_e   state_q, state_d;

  logic                       psel_q, penable_q, pwrite_q;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
  logic [AMBA_WORD-1:0]       pwdata_q, rsp_rdata_q;
  logic                       rsp_valid_q, rsp_write_q;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .T     (cmd_loc_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (cmd_valid),
    .push_data_i (push_cmd),
    .ready_o     (cmd_ready),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SETUP;
          pop     = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (!fifo_empty) begin
          state_d = SETUP;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
      if (pop) begin
        paddr_q  <= head.addr;
        pwrite_q <= head.write;
        pwdata_q <= head.write ? head.wdata : '0;
      end
      rsp_valid_q <= (state_q == ACCESS);
      if (state_q == ACCESS) begin
        rsp_write_q <= pwrite_q;
        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
      end
    end
  end

  assign busy      = !fifo_empty || (state_q != IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: zero-wait APB slave memory, scoreboard of expected
// transfers/responses, plus cycle-exact directed checks.
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata, PWDATA, PRDATA;
  logic [19:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;

  apb_cmd_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .busy(busy), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct packed { logic w; logic [19:0] a; logic [31:0] d; } bus_t;
  typedef struct packed { logic w; logic [31:0] d; } rsp_t;
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Zero-wait slave memory; mdl_mem is the bench's in-order view of it.
  logic [31:0] slv_mem [16];
  logic [31:0] mdl_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = {16'hC0DE, 16'(i * 4)};
      mdl_mem[i] = {16'hC0DE, 16'(i * 4)};
    end
    slv_mem[2] = 32'hFFFF_FFFF;  mdl_mem[2] = 32'hFFFF_FFFF;
    slv_mem[4] = 32'h0000_00A5;  mdl_mem[4] = 32'h0000_00A5;
  end
  assign PRDATA = (PSEL && PENABLE) ? slv_mem[PADDR[5:2]] : {16'hDEAD, cyc[15:0]};
  initial forever begin
    @(posedge clk);
    if (rst && PSEL && PENABLE && PWRITE) slv_mem[PADDR[5:2]] = PWDATA;
  end

  // Record expectations for every accepted command.
  initial forever begin
    bus_t b;
    rsp_t r;
    int   idx;
    @(posedge clk);
    if (rst && cmd_valid && cmd_ready) begin
      idx = int'(cmd_addr[5:2]);
      b.w = cmd_write; b.a = cmd_addr; b.d = cmd_write ? cmd_wdata : 32'h0;
      r.w = cmd_write; r.d = cmd_write ? 32'h0 : mdl_mem[idx];
      if (cmd_write) mdl_mem[idx] = cmd_wdata;
      exp_bus.push_back(b);
      exp_rsp.push_back(r);
    end
  end

  initial forever begin
    @(negedge rst);
    exp_bus.delete();
    exp_rsp.delete();
  end

  // Bus/response monitor.
  initial begin
    logic prev_setup = 1'b0, prev_rsp = 1'b0;
    bus_t cur = '0;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_setup = 1'b0;
        prev_rsp   = 1'b0;
      end else begin
        if (PSEL && !PENABLE) begin
          if (exp_bus.size() == 0) check_eq("bus_unexpected", 1, 0);
          else begin
            cur = exp_bus.pop_front();
            check_eq("setup_paddr", PADDR, cur.a);
            check_eq("setup_pwrite", PWRITE, cur.w);
            check_eq("setup_pwdata", PWDATA, cur.d);
          end
        end
        if (PENABLE) begin
          check_eq("access_psel", PSEL, 1);
          check_eq("access_after_setup", prev_setup, 1);
          check_eq("access_paddr", PADDR, cur.a);
          check_eq("access_pwrite", PWRITE, cur.w);
          check_eq("access_pwdata", PWDATA, cur.d);
        end
        if (rsp_valid) begin
          check_eq("rsp_pulse_width", prev_rsp, 0);
          if (exp_rsp.size() == 0) check_eq("rsp_unexpected", 1, 0);
          else begin
            r = exp_rsp.pop_front();
            check_eq("rsp_write", rsp_write, r.w);
            check_eq("rsp_rdata", rsp_rdata, r.d);
          end
          $display("rsp %s rdata=%08h t=%0t", rsp_write ? "W" : "R", rsp_rdata, $time);
        end
        prev_setup = PSEL && !PENABLE;
        prev_rsp   = rsp_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic drive_cmd(input logic w, input logic [19:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((exp_rsp.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", (exp_rsp.size() == 0 && !busy), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic single(input logic w, input logic [19:0] a, input logic [31:0] d,
                        input logic [31:0] rd);
    @(posedge clk); #1;
    drive_cmd(w, a, d);
    @(posedge clk); #1;
    idle_cmd();
    @(negedge clk);
    check_eq("c1_psel", PSEL, 0);
    check_eq("c1_busy", busy, 1);
    @(negedge clk);
    check_eq("c2_psel", PSEL, 1);
    check_eq("c2_penable", PENABLE, 0);
    check_eq("c2_paddr", PADDR, a);
    check_eq("c2_pwrite", PWRITE, w);
    check_eq("c2_pwdata", PWDATA, w ? d : 32'h0);
    @(negedge clk);
    check_eq("c3_penable", PENABLE, 1);
    @(negedge clk);
    check_eq("c4_rsp_valid", rsp_valid, 1);
    check_eq("c4_rsp_write", rsp_write, w);
    check_eq("c4_rsp_rdata", rsp_rdata, w ? 32'h0 : rd);
    @(negedge clk);
    check_eq("c5_rsp_valid", rsp_valid, 0);
    check_eq("c5_busy", busy, 0);
    wait_drain(20);
  endtask

  task automatic burst4();
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          drive_cmd(k < 2, 20'(k * 4), 32'h1111_1111 * (k + 1));
          @(posedge clk); #1;
        end
        idle_cmd();
      end
      begin
        for (int c = 0; c <= 11; c++) begin
          @(negedge clk);
          check_eq("burst_ready", cmd_ready, 1);
          if (c >= 2 && c <= 9) begin
            check_eq("burst_psel", PSEL, 1);
            check_eq("burst_penable", PENABLE, (c % 2) == 1);
          end
          if (c == 10) check_eq("burst_psel_end", PSEL, 0);
          if (c >= 4) check_eq("burst_rsp_valid", rsp_valid, (c % 2) == 0 && c <= 10);
        end
      end
    join
    wait_drain(20);
  endtask

  task automatic read_then_write();
    @(posedge clk); #1;
    drive_cmd(1'b0, 20'h00008, 32'h0);
    @(posedge clk); #1;
    drive_cmd(1'b1, 20'h00008, 32'h1234_5678);
    @(posedge clk); #1;
    idle_cmd();
    @(negedge clk);  // cycle 2: read SETUP
    check_eq("rw_c2_pwrite", PWRITE, 0);
    check_eq("rw_c2_pwdata", PWDATA, 32'h0);
    @(negedge clk);
    check_eq("rw_c3_pwdata", PWDATA, 32'h0);
    @(negedge clk);  // cycle 4: read response, write SETUP
    check_eq("rw_c4_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
    check_eq("rw_c4_pwdata", PWDATA, 32'h1234_5678);
    check_eq("rw_c4_penable", PENABLE, 0);
    @(negedge clk);
    check_eq("rw_c5_pwdata", PWDATA, 32'h1234_5678);
    check_eq("rw_c5_penable", PENABLE, 1);
    wait_drain(20);
  endtask

  task automatic full_queue();
    int tcur, n, exp_c;
    logic acc;
    @(posedge clk); #1;
    tcur = 0;
    for (int k = 0; k < 9; k++) begin
      drive_cmd((k % 2) == 0, 20'(k * 4), 32'hA000_0000 | k);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
        @(posedge clk);
        acc = cmd_ready;
        n++;
      end
      exp_c = (k < 7) ? k : ((k == 7) ? 8 : 10);
      check_eq($sformatf("full_accept_cycle_%0d", k), tcur + n - 1, exp_c);
      tcur += n;
      #1;
    end
    idle_cmd();
    wait_drain(60);
  endtask

  task automatic reset_in_access();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive_cmd(1'b0, 20'h00010 + 20'(k * 4), 32'h0);
      @(posedge clk); #1;
    end
    idle_cmd();
    #2;  // cycle 3: first read in ACCESS
    check_eq("rst_pre_penable", PENABLE, 1);
    rst = 1'b0;
    #1;
    check_eq("rst_async_psel", PSEL, 0);
    check_eq("rst_async_penable", PENABLE, 0);
    check_eq("rst_async_rsp_valid", rsp_valid, 0);
    check_eq("rst_async_busy", busy, 0);
    check_eq("rst_async_ready", cmd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_rel_ready", cmd_ready, 1);
    check_eq("rst_rel_busy", busy, 0);
    repeat (4) begin
      @(negedge clk);
      check_eq("rst_no_rsp", rsp_valid, 0);
      check_eq("rst_no_psel", PSEL, 0);
    end
  endtask

  initial begin
    idle_cmd();
    repeat (3) @(negedge clk);
    check_eq("reset_psel", PSEL, 0);
    check_eq("reset_penable", PENABLE, 0);
    check_eq("reset_paddr", PADDR, 0);
    check_eq("reset_pwrite", PWRITE, 0);
    check_eq("reset_pwdata", PWDATA, 0);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp_write", rsp_write, 0);
    check_eq("reset_rsp_rdata", rsp_rdata, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_ready", cmd_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("release_ready", cmd_ready, 1);

    single(1'b1, 20'h00004, 32'hDEAD_BEEF, 32'h0);
    single(1'b0, 20'h00010, 32'h0, 32'h0000_00A5);
    burst4();
    read_then_write();
    full_queue();
    reset_in_access();
    single(1'b1, 20'h00024, 32'hCAFE_F00D, 32'h0);
    single(1'b0, 20'h00024, 32'h0, 32'hCAFE_F00D);

    check_eq("bus_queue_empty", exp_bus.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
